lsu_arbiter_ipa: RTL and testbench

// - Shares one TCDM-style memory port between the NB_TILES tile LSU ports of the CGRA array.
// - Arbitrates per-tile load/store requests round-robin with one transaction outstanding.
// - Returns grant, rvalid and read data to the winning tile.
// - Drives per-tile stall lines that are OR-reduced into each tile's Stall_In.

---
 rtl/lsu_arbiter_ipa.sv | 160 ++++++++++++++++
 tb/tb_lsu_arbiter_ipa.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter_ipa.sv
// lsu_arbiter_ipa
// Shares one TCDM-style memory port between NB_TILES tile LSU ports.
// Only one transaction is outstanding at a time. The state sequence is
// IDLE -> REQ -> WAIT -> IDLE.
//
// Arbitration:
//   - Default build: round-robin, starting from r_rr_ptr.
//   - With the macro LSU_ARB_FIXED_PRIO_EN defined: fixed priority, and the
//     lowest index wins. r_rr_ptr is then held at 0.
//
// Ports:
//   Clk, Reset                clock; asynchronous active-low reset
//   tile_req_i/we_i           per-tile request and store flag
//   tile_addr_i/wdata_i       packed per-tile address/store data (tile i at [i*W +: W])
//   tile_gnt_o                one-hot grant pulse, combinational from mem_gnt_i
//   tile_rvalid_o             one-hot response pulse, combinational from mem_rvalid_i
//   tile_rdata_o              read data broadcast (0 when mem_rvalid_i low)
//   stall_o                   per-tile stall contribution
//   mem_req/we/addr/wdata_o   memory request side
//   mem_gnt/rvalid/rdata_i    memory grant and response side
//   busy_o                    high when not IDLE
//   proto_err_o               sticky flag: an rvalid arrived outside WAIT
module lsu_arbiter_ipa #(
   parameter int NB_TILES = 16,
   parameter int AWIDTH   = 32,
   parameter int DWIDTH   = 32
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NB_TILES-1:0]        tile_req_i,
   input  logic [NB_TILES-1:0]        tile_we_i,
   input  logic [NB_TILES*AWIDTH-1:0] tile_addr_i,
   input  logic [NB_TILES*DWIDTH-1:0] tile_wdata_i,
   output logic [NB_TILES-1:0]        tile_gnt_o,
   output logic [NB_TILES-1:0]        tile_rvalid_o,
   output logic [DWIDTH-1:0]          tile_rdata_o,
   output logic [NB_TILES-1:0]        stall_o,
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [AWIDTH-1:0]          mem_addr_o,
   output logic [DWIDTH-1:0]          mem_wdata_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [DWIDTH-1:0]          mem_rdata_i,
   output logic                       busy_o,
   output logic                       proto_err_o
);

   localparam int IW = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [IW-1:0]       r_rr_ptr;
   logic [IW-1:0]       r_win;
   logic                r_we;
   logic [AWIDTH-1:0]   r_addr;
   logic [DWIDTH-1:0]   r_wdata;
   logic                r_proto_err;

   logic                  w_any;
   logic [2*NB_TILES-1:0] w_req_shift;
   logic [NB_TILES-1:0]   w_req_rot;
   logic [IW-1:0]         w_off;
   logic [IW:0]           w_sum;
   logic [IW-1:0]         w_pick;

   // Rotate the request vector so that bit 0 is the tile at r_rr_ptr.
   // The lowest set bit of the rotated vector is then the winner offset.
   // In fixed-priority mode r_rr_ptr stays 0, so the same logic gives
   // lowest-index priority.
   assign w_any       = |tile_req_i;
   assign w_req_shift = {tile_req_i, tile_req_i} >> r_rr_ptr;
   assign w_req_rot   = w_req_shift[NB_TILES-1:0];

   always_comb begin
      w_off = '0;
      for (int k = NB_TILES - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_off = IW'(k);
         end
      end
   end

   // Map the offset back to an absolute tile index, wrapping modulo NB_TILES.
   assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_pick = (w_sum >= (IW+1)'(NB_TILES)) ? IW'(w_sum - (IW+1)'(NB_TILES))
                                                  : w_sum[IW-1:0];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_win       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && w_any) begin
            r_win   <= w_pick;
            r_we    <= tile_we_i[w_pick];
            r_addr  <= tile_addr_i[w_pick*AWIDTH +: AWIDTH];
            r_wdata <= tile_wdata_i[w_pick*DWIDTH +: DWIDTH];
         end
`ifdef LSU_ARB_FIXED_PRIO_EN
         r_rr_ptr <= '0;
`else
         if (r_state == REQ && mem_gnt_i) begin
            r_rr_ptr <= (r_win == IW'(NB_TILES - 1)) ? '0 : r_win + 1'b1;
         end
`endif
         if (mem_rvalid_i && r_state != WAIT) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      mem_req_o     = 1'b0;
      tile_gnt_o    = '0;
      tile_rvalid_o = '0;
      case (r_state)
         IDLE: begin
            if (w_any) w_state_next = REQ;
         end
         REQ: begin
            mem_req_o         = 1'b1;
            tile_gnt_o[r_win] = mem_gnt_i;
            if (mem_gnt_i) w_state_next = WAIT;
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               tile_rvalid_o[r_win] = 1'b1;
               w_state_next         = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign mem_we_o     = r_we;
   assign mem_addr_o   = r_addr;
   assign mem_wdata_o  = r_wdata;
   assign tile_rdata_o = mem_rvalid_i ? mem_rdata_i : '0;
   assign busy_o       = (r_state != IDLE);
   assign proto_err_o  = r_proto_err;

   // A tile keeps stalling while its own transaction is in flight,
   // even if it has already dropped its request.
   generate
      for (genvar gi = 0; gi < NB_TILES; gi++) begin : g_stall
         assign stall_o[gi] = tile_req_i[gi] | (busy_o & (r_win == IW'(gi)));
      end
   endgenerate

endmodule

// File: tb/tb_lsu_arbiter_ipa.sv
// Directed testbench for lsu_arbiter_ipa (NB_TILES=16, AWIDTH=DWIDTH=32).
module tb_lsu_arbiter_ipa;

   localparam int N = 16;

   logic            Clk = 1'b0;
   logic            Reset = 1'b0;
   logic [N-1:0]    tile_req_i = '0;
   logic [N-1:0]    tile_we_i = '0;
   logic [N*32-1:0] tile_addr_i = '0;
   logic [N*32-1:0] tile_wdata_i = '0;
   logic [N-1:0]    tile_gnt_o;
   logic [N-1:0]    tile_rvalid_o;
   logic [31:0]     tile_rdata_o;
   logic [N-1:0]    stall_o;
   logic            mem_req_o;
   logic            mem_we_o;
   logic [31:0]     mem_addr_o;
   logic [31:0]     mem_wdata_o;
   logic            mem_gnt_i = 1'b0;
   logic            mem_rvalid_i = 1'b0;
   logic [31:0]     mem_rdata_i = '0;
   logic            busy_o;
   logic            proto_err_o;

   int n_cmp = 0;
   int n_bad = 0;

   lsu_arbiter_ipa #(.NB_TILES(N), .AWIDTH(32), .DWIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset),
      .tile_req_i(tile_req_i), .tile_we_i(tile_we_i),
      .tile_addr_i(tile_addr_i), .tile_wdata_i(tile_wdata_i),
      .tile_gnt_o(tile_gnt_o), .tile_rvalid_o(tile_rvalid_o),
      .tile_rdata_o(tile_rdata_o), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
   );

   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Waits (bounded) for mem_req_o, grants at once, then answers one cycle later.
   // It records the observed grant and rvalid vectors; it does not judge them.
   task automatic run_txn(input logic [31:0] rdata, output logic [N-1:0] g,
                          output logic [N-1:0] rv, output bit tmo);
      tmo = 1'b1;
      g   = '0;
      rv  = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_req_o) begin
            tmo = 1'b0;
            break;
         end
      end
      if (!tmo) begin
         mem_gnt_i = 1'b1;
         #1 g = tile_gnt_o;
         tick();
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = rdata;
         #1 rv = tile_rvalid_o;
         tick();
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = '0;
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({mem_req_o, busy_o, proto_err_o, mem_we_o} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got req/busy/err/we=%b required 0000",
                  {mem_req_o, busy_o, proto_err_o, mem_we_o});
      end
      n_cmp++;
      if ({tile_gnt_o, tile_rvalid_o, stall_o} !== '0 || mem_addr_o !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_vec: got gnt=%h rv=%h stall=%h addr=%h required all 0",
                  tile_gnt_o, tile_rvalid_o, stall_o, mem_addr_o);
      end
      tick();
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_single_load();
      tile_addr_i[3*32 +: 32] = 32'h40;
      tile_we_i[3]  = 1'b0;
      tile_req_i    = 16'h0008;
      tick();
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_we_o !== 1'b0) begin
         n_bad++;
         $display("FAIL load_req: got req=%b addr=%h we=%b required 1 00000040 0",
                  mem_req_o, mem_addr_o, mem_we_o);
      end
      n_cmp++;
      if (tile_gnt_o !== 16'h0) begin
         n_bad++;
         $display("FAIL load_nognt: got gnt=%h required 0000", tile_gnt_o);
      end
      tick();
      mem_gnt_i = 1'b1;
      #1;
      n_cmp++;
      if (tile_gnt_o !== 16'h0008) begin
         n_bad++;
         $display("FAIL load_gnt: got gnt=%h required 0008", tile_gnt_o);
      end
      tick();
      mem_gnt_i  = 1'b0;
      tile_req_i = '0;
      #1;
      n_cmp++;
      if (mem_req_o !== 1'b0 || tile_gnt_o !== 16'h0 || busy_o !== 1'b1 || stall_o !== 16'h0008) begin
         n_bad++;
         $display("FAIL load_wait: got req=%b gnt=%h busy=%b stall=%h required 0 0000 1 0008",
                  mem_req_o, tile_gnt_o, busy_o, stall_o);
      end
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEADBEEF;
      #1;
      n_cmp++;
      if (tile_rvalid_o !== 16'h0008 || tile_rdata_o !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL load_rvalid: got rv=%h rdata=%h required 0008 deadbeef",
                  tile_rvalid_o, tile_rdata_o);
      end
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      #1;
      n_cmp++;
      if (busy_o !== 1'b0 || tile_rdata_o !== 32'h0 || tile_rvalid_o !== 16'h0) begin
         n_bad++;
         $display("FAIL load_idle: got busy=%b rdata=%h rv=%h required 0 0 0",
                  busy_o, tile_rdata_o, tile_rvalid_o);
      end
   endtask

   task automatic test_store();
      tile_addr_i[0 +: 32]  = 32'h100;
      tile_wdata_i[0 +: 32] = 32'h12345678;
      tile_we_i[0]          = 1'b1;
      tile_req_i            = 16'h0001;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++;
         if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h100 ||
             mem_wdata_o !== 32'h12345678) begin
            n_bad++;
            $display("FAIL store_req%0d: got req=%b we=%b addr=%h wdata=%h required 1 1 00000100 12345678",
                     c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
         end
      end
      mem_gnt_i = 1'b1;
      #1;
      n_cmp++;
      if (tile_gnt_o !== 16'h0001) begin
         n_bad++;
         $display("FAIL store_gnt: got gnt=%h required 0001", tile_gnt_o);
      end
      tick();
      mem_gnt_i    = 1'b0;
      tile_req_i   = '0;
      tile_we_i[0] = 1'b0;
      mem_rvalid_i = 1'b1;
      #1;
      n_cmp++;
      if (tile_rvalid_o !== 16'h0001) begin
         n_bad++;
         $display("FAIL store_rvalid: got rv=%h required 0001", tile_rvalid_o);
      end
      tick();
      mem_rvalid_i = 1'b0;
   endtask

   task automatic test_round_robin();
      int exp_win[4];
      logic [N-1:0] g;
      logic [N-1:0] rv;
      bit tmo;
`ifdef LSU_ARB_FIXED_PRIO_EN
      exp_win = '{1, 1, 1, 1};
`else
      exp_win = '{1, 5, 15, 1};
`endif
      tile_req_i = 16'h8022;
      for (int n = 0; n < 4; n++) begin
         run_txn(32'hA000 + n, g, rv, tmo);
         n_cmp++;
         if (tmo || g !== (16'h1 << exp_win[n]) || rv !== (16'h1 << exp_win[n])) begin
            n_bad++;
            $display("FAIL rr_order%0d: got gnt=%h rv=%h timeout=%0d required tile %0d",
                     n, g, rv, tmo, exp_win[n]);
         end
      end
      tile_req_i = '0;
      tick();
   endtask

   task automatic test_backpressure();
      logic ok;
      tile_addr_i[7*32 +: 32] = 32'h77;
      tile_req_i = 16'h0080;
      tick();
      tile_req_i = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h77 || stall_o !== 16'h0080 ||
             tile_gnt_o !== 16'h0) begin
            n_bad++;
            $display("FAIL bp_cycle%0d: got req=%b addr=%h stall=%h gnt=%h required 1 00000077 0080 0000",
                     c, mem_req_o, mem_addr_o, stall_o, tile_gnt_o);
         end
         tick();
      end
      mem_gnt_i = 1'b1;
      #1 ok = (tile_gnt_o === 16'h0080);
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      #1;
      n_cmp++;
      if (!ok || tile_rvalid_o !== 16'h0080) begin
         n_bad++;
         $display("FAIL bp_finish: got gnt_ok=%b rv=%h required 1 0080", ok, tile_rvalid_o);
      end
      tick();
      mem_rvalid_i = 1'b0;
   endtask

   task automatic test_stray_rvalid();
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hAA;
      #1;
      n_cmp++;
      if (tile_rvalid_o !== 16'h0 || tile_gnt_o !== 16'h0 || proto_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_comb: got rv=%h gnt=%h err=%b required 0000 0000 0",
                  tile_rvalid_o, tile_gnt_o, proto_err_o);
      end
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      #1;
      n_cmp++;
      if (proto_err_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_err: got err=%b busy=%b required 1 0", proto_err_o, busy_o);
      end
      tick();
      tick();
      n_cmp++;
      if (proto_err_o !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_sticky: got err=%b busy=%b req=%b required 1 0 0",
                  proto_err_o, busy_o, mem_req_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] g;
      logic [N-1:0] rv;
      bit tmo;
      tile_req_i = 16'h0200;
      tick();
      tile_req_i = '0;
      mem_gnt_i  = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      #1;
      n_cmp++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_wait: got busy=%b req=%b required 1 0", busy_o, mem_req_o);
      end
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || proto_err_o !== 1'b0 || stall_o !== 16'h0) begin
         n_bad++;
         $display("FAIL rmid_async: got busy=%b req=%b err=%b stall=%h required 0 0 0 0000",
                  busy_o, mem_req_o, proto_err_o, stall_o);
      end
      #1 Reset = 1'b1;
      // Tiles 2 and 14 request; with the pointer back at 0, tile 2 must win.
      tile_req_i = 16'h4004;
      run_txn(32'h5, g, rv, tmo);
      tile_req_i = '0;
      n_cmp++;
      if (tmo || g !== 16'h0004 || rv !== 16'h0004) begin
         n_bad++;
         $display("FAIL rmid_rrptr: got gnt=%h rv=%h timeout=%0d required 0004 0004 0",
                  g, rv, tmo);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_store();
      test_round_robin();
      test_backpressure();
      test_stray_rvalid();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
